// File: rtl/button_pkg.sv
// Shared types for the button debouncer: per-channel FSM states and counter sizing.
package button_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_PRESSED     = 3'd2,
    ST_LONG        = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } btn_state_t;

  // One spare bit above the larger threshold so saturation never aliases a threshold.
  function automatic int cnt_width(input int deb_cycles, input int long_cycles);
    int m;
    m = (deb_cycles > long_cycles) ? deb_cycles : long_cycles;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// Single button: synchronizer, debounce FSM, long-press detect; all outputs registered.
// Accepted edge strobes one cycle after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
module button_channel
  import button_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   LONG_CYCLES     = 50000000,
  parameter int   SYNC_STAGES     = 2,
  parameter logic ACTIVE_LOW      = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_long_pulse,
  output logic o_held
);

  localparam int             CW        = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam logic [CW-1:0]  DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MAX   = '1;
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  btn_state_t             r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                   w_level_nxt, w_held_nxt;
  logic                   w_press_nxt, w_release_nxt, w_long_nxt;

  // Synchronizer parks at the released raw level so reset never looks like a press.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= {SYNC_STAGES{ACTIVE_LOW}};
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_raw};
  end

  assign w_s       = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = o_level;
    w_held_nxt    = o_held;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_s) begin
          w_state_nxt = ST_DEB_PRESS;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ST_DEB_PRESS: begin
        if (!w_s) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= DEB_LAST) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
          w_level_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_PRESSED: begin
        if (!w_s) begin
          w_state_nxt = ST_DEB_RELEASE;
          w_cnt_nxt   = CNT_ONE;
        end else if (r_cnt >= LONG_LAST) begin
          w_state_nxt = ST_LONG;
          w_cnt_nxt   = '0;
          w_long_nxt  = 1'b1;
          w_held_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_LONG: begin
        w_cnt_nxt = '0;
        if (!w_s) begin
          w_state_nxt = ST_DEB_RELEASE;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ST_DEB_RELEASE: begin
        // held doubles as the memory of which pressed state we came from
        if (w_s) begin
          w_state_nxt = o_held ? ST_LONG : ST_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= DEB_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = '0;
          w_release_nxt = 1'b1;
          w_level_nxt   = 1'b0;
          w_held_nxt    = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      o_level         <= 1'b0;
      o_held          <= 1'b0;
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
      o_long_pulse    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      o_level         <= w_level_nxt;
      o_held          <= w_held_nxt;
      o_press_pulse   <= w_press_nxt;
      o_release_pulse <= w_release_nxt;
      o_long_pulse    <= w_long_nxt;
    end
  end

endmodule

// File: rtl/button_bank.sv
// Bank of N_BTN independent debounced buttons with press/release/long-press strobes.
// Latency per channel: SYNC_STAGES+DEBOUNCE_CYCLES cycles from a stable raw edge.
module button_bank
  import button_pkg::*;
#(
  parameter int               N_BTN           = 4,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               LONG_CYCLES     = 50000000,
  parameter int               SYNC_STAGES     = 2,
  parameter logic [N_BTN-1:0] ACTIVE_LOW      = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_btn_raw,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press_pulse,
  output logic [N_BTN-1:0] o_release_pulse,
  output logic [N_BTN-1:0] o_long_pulse,
  output logic [N_BTN-1:0] o_held
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .ACTIVE_LOW      (ACTIVE_LOW[g])
    ) u_ch (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_btn_raw       (i_btn_raw[g]),
      .o_level         (o_level[g]),
      .o_press_pulse   (o_press_pulse[g]),
      .o_release_pulse (o_release_pulse[g]),
      .o_long_pulse    (o_long_pulse[g]),
      .o_held          (o_held[g])
    );
  end

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: expected strobes are queued with their due cycle
// when stimulus is driven, and every cycle all outputs are compared to the queue.
module tb_button_bank;

  localparam int         N  = 4;
  localparam int         LAT = 6;   // drive after edge c -> strobe visible after edge c+6
  localparam int         LNG = 16;  // long strobe: LAT + LONG_CYCLES

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] level, press_p, release_p, long_p, held;

  button_bank #(
    .N_BTN           (4),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (10),
    .SYNC_STAGES     (2),
    .ACTIVE_LOW      (4'b1000)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_btn_raw       (btn),
    .o_level         (level),
    .o_press_pulse   (press_p),
    .o_release_pulse (release_p),
    .o_long_pulse    (long_p),
    .o_held          (held)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
    logic [N-1:0] lg;
    bit           clr;
  } ev_t;

  ev_t          q[$];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  logic [N-1:0] exp_level = '0;
  logic [N-1:0] exp_held  = '0;

  task automatic push(input int at, input logic [N-1:0] pr, input logic [N-1:0] rl,
                      input logic [N-1:0] lg, input bit clr);
    ev_t e;
    e.cyc = at; e.pr = pr; e.rl = rl; e.lg = lg; e.clr = clr;
    q.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] epr, erl, elg;
    bit           clr;
    epr = '0; erl = '0; elg = '0; clr = 1'b0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        epr |= q[i].pr;
        erl |= q[i].rl;
        elg |= q[i].lg;
        clr |= q[i].clr;
        q.delete(i);
      end
    end
    if (clr) begin
      exp_level = '0;
      exp_held  = '0;
    end
    exp_level = (exp_level | epr) & ~erl;
    exp_held  = (exp_held | elg) & ~erl;
    cmp("press_pulse",   press_p,   epr);
    cmp("release_pulse", release_p, erl);
    cmp("long_pulse",    long_p,    elg);
    cmp("level",         level,     exp_level);
    cmp("held",          held,      exp_held);
  endtask

  // Advance one clock, then check outputs at the falling edge; stimulus follows.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  int c;

  initial begin
    rst = 1'b1;
    btn = 4'b1000;           // channel 3 is active-low: raw 1 = released
    wait_cycles(3);          // reset state checked on every one of these cycles
    rst = 1'b0;
    wait_cycles(4);

    // Single press held long enough for a long-press, then released.
    btn[0] = 1'b1;
    push(cyc + LAT, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    push(cyc + LNG, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    wait_cycles(20);
    btn[0] = 1'b0;
    push(cyc + LAT, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    wait_cycles(10);

    // Bouncing press on channel 1: only the final steady level is accepted.
    repeat (2) begin
      btn[1] = 1'b1; wait_cycles(2);
      btn[1] = 1'b0; wait_cycles(2);
    end
    btn[1] = 1'b1;
    push(cyc + LAT, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    wait_cycles(12);
    btn[1] = 1'b0;
    push(cyc + LAT, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    wait_cycles(10);

    // Active-low channel 3 pressed by driving raw low.
    btn[3] = 1'b0;
    push(cyc + LAT, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    wait_cycles(8);
    btn[3] = 1'b1;
    push(cyc + LAT, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    wait_cycles(10);

    // Simultaneous presses on channels 0 and 2.
    btn[0] = 1'b1; btn[2] = 1'b1;
    push(cyc + LAT, 4'b0101, 4'b0000, 4'b0000, 1'b0);
    wait_cycles(10);
    btn[0] = 1'b0; btn[2] = 1'b0;
    push(cyc + LAT, 4'b0000, 4'b0101, 4'b0000, 1'b0);
    wait_cycles(10);

    // Reset while channel 0 is in long-press; button stays down through reset.
    btn[0] = 1'b1;
    push(cyc + LAT, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    push(cyc + LNG, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    wait_cycles(20);
    rst = 1'b1;
    push(cyc + 1, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    wait_cycles(3);
    rst = 1'b0;
    push(cyc + LAT, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    push(cyc + LNG, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    wait_cycles(20);
    btn[0] = 1'b0;
    push(cyc + LAT, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    wait_cycles(10);

    // Release from long-press with a one-cycle glitch back to pressed.
    btn[0] = 1'b1;
    push(cyc + LAT, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    push(cyc + LNG, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    wait_cycles(20);
    btn[0] = 1'b0;
    wait_cycles(2);
    btn[0] = 1'b1;
    wait_cycles(1);
    btn[0] = 1'b0;
    push(cyc + LAT, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    wait_cycles(12);

    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0 pending events", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_bank.md
BUTTON_BANK -- requirements
Module: button_bank

Interface
REQ-001 Parameter N_BTN, default 4: number of independent button channels (1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a level change (>=2).
REQ-003 Parameter LONG_CYCLES, default 50000000: cycles a press is held after acceptance before long_pulse fires (> DEBOUNCE_CYCLES).
REQ-004 Parameter SYNC_STAGES, default 2: synchronizer flop depth (2..3).
REQ-005 Parameter ACTIVE_LOW, default all zeros, N_BTN bits: bit i=1 means btn_raw[i] is pressed when 0.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 btn_raw  input  N_BTN  asynchronous raw pushbutton levels.
REQ-009 level  output  N_BTN  debounced pressed state, 1 = pressed.
REQ-010 press_pulse  output  N_BTN  one-cycle strobe on accepted press.
REQ-011 release_pulse  output  N_BTN  one-cycle strobe on accepted release.
REQ-012 long_pulse  output  N_BTN  one-cycle strobe when press reaches LONG_CYCLES.
REQ-013 held  output  N_BTN  high from long_pulse cycle until accepted release.

Function
REQ-014 Each channel SHALL pass btn_raw[i] through SYNC_STAGES flops, then XOR with ACTIVE_LOW[i] to give normalized active-high sample s.
REQ-015 Each channel SHALL run an FSM with states IDLE, DEB_PRESS, PRESSED, LONG, DEB_RELEASE and one counter of width clog2(max(DEBOUNCE_CYCLES,LONG_CYCLES))+1.
REQ-016 IDLE: s=1 -> DEB_PRESS, counter=1; else stay.
REQ-017 DEB_PRESS: s=0 -> IDLE (bounce, counter cleared); counter reaching DEBOUNCE_CYCLES with s=1 -> PRESSED, press_pulse=1 that cycle, level=1, counter cleared.
REQ-018 PRESSED: counter increments each cycle; s=0 -> DEB_RELEASE, counter=1; counter reaching LONG_CYCLES -> LONG, long_pulse=1, held=1.
REQ-019 LONG: s=0 -> DEB_RELEASE, counter=1; no further long_pulse while held.
REQ-020 DEB_RELEASE: s=1 -> return to PRESSED or LONG (whichever preceded), PRESSED resuming its hold count from zero; counter reaching DEBOUNCE_CYCLES with s=0 -> IDLE, release_pulse=1, level=0, held=0.
REQ-021 Latency: raw edge stable before clock edge k yields press_pulse/release_pulse in the cycle after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
REQ-022 level and held SHALL stay constant through a rejected bounce in either direction.
REQ-023 All pulses SHALL be registered, exactly one cycle wide, and never coincide with the same channel's other pulses.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels produce simultaneous pulses.
REQ-025 Counters SHALL saturate rather than wrap; no pulse is ever generated by wrap-around.

Reset
REQ-026 While rst=1 at a clock edge: all FSMs to IDLE, counters 0, synchronizer flops to the released level (ACTIVE_LOW[i]), all outputs 0.
REQ-027 Reset mid-press SHALL abort without release_pulse; a button still pressed after rst deasserts SHALL produce a normal press_pulse after full sync+debounce latency.

Structure
REQ-028 Package button_pkg SHALL hold the FSM state enumeration and the counter-width function.
REQ-029 One sub-module button_channel SHALL implement REQ-014..REQ-025 for a single channel; button_bank instantiates N_BTN copies via generate.

Verification (N_BTN=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, SYNC_STAGES=2, ACTIVE_LOW=4'b1000)
REQ-030 btn_raw[0] 0->1 held 20 cycles -> press_pulse[0] once at latency 5, long_pulse[0] and held[0] 10 cycles later, nothing else.
REQ-031 btn_raw[1] toggles 1,0,1,0 each 2 cycles then steady 1 -> exactly one press_pulse[1], level[1] never high during the toggling.
REQ-032 btn_raw[3]=1 after reset (active-low, released) then driven 0 for 8 cycles -> press_pulse[3] then release_pulse[3], level[3] high between.
REQ-033 btn_raw[0] and btn_raw[2] rise in the same cycle -> press_pulse[0] and press_pulse[2] asserted in the same cycle.
REQ-034 rst asserted while channel 0 is in LONG -> all outputs 0 next cycle, no release_pulse; button still pressed -> fresh press_pulse after 5 cycles post-reset.
REQ-035 Release with one 1-cycle glitch back to pressed mid-debounce -> release_pulse delayed, held remains 1 until the accepted release.
